// File: rtl/nrs_cinit_gen.sv
// NRS scrambling-seed generator: c_init = 2^10*(7(ns+1)+l+1)*(2N+1) + 2N+1,
// computed per request with a sequential shift-add multiplier.
module nrs_cinit_gen #(
    parameter int NS_W    = 5,
    parameter int NID_W   = 9,
    parameter int L_W     = 3,
    parameter int NS_MAX  = 19,
    parameter int L_MAX   = 6,
    parameter int CINIT_W = 31
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [NS_W-1:0]    ns_in,
    input  logic [L_W-1:0]     l_in,
    input  logic [NID_W-1:0]   n_cell_id,
    output logic               busy,
    output logic [CINIT_W-1:0] cinit,
    output logic               valid,
    output logic               err
);

    localparam int MW    = NID_W + 1;
    localparam int A_MAX = 7 * (NS_MAX + 1) + L_MAX + 1;
    localparam int A_W   = $clog2(A_MAX + 1);
    localparam int P_W   = A_W + MW;
    localparam int CNT_W = $clog2(MW);

    localparam logic [NS_W-1:0]  NS_MAX_V = NS_MAX[NS_W-1:0];
    localparam logic [L_W-1:0]   L_MAX_V  = L_MAX[L_W-1:0];
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MW - 1);

    typedef enum logic [1:0] {IDLE, MULT, ADD, DONE} state_t;

    state_t           state;
    logic [A_W-1:0]   a;
    logic [MW-1:0]    b;
    logic [P_W-1:0]   acc;
    logic [CNT_W-1:0] cnt;
    logic             legal;

    // 7(ns+1) formed as 8(ns+1)-(ns+1); wrap-around in A_W bits cancels out
    function automatic logic [A_W-1:0] symbol_term(input logic [NS_W-1:0] ns,
                                                   input logic [L_W-1:0]  l);
        logic [A_W-1:0] ns1;
        ns1 = A_W'(ns) + A_W'(1);
        return (ns1 << 3) - ns1 + A_W'(l) + A_W'(1);
    endfunction

    function automatic logic [P_W-1:0] partial(input logic [A_W-1:0]   op_a,
                                               input logic [MW-1:0]    op_b,
                                               input logic [CNT_W-1:0] bit_idx);
        return op_b[bit_idx] ? (P_W'(op_a) << bit_idx) : '0;
    endfunction

    function automatic logic [CINIT_W-1:0] final_sum(input logic [P_W-1:0] prod,
                                                     input logic [MW-1:0]  op_b);
        return CINIT_W'({prod, 10'd0}) + CINIT_W'(op_b);
    endfunction

    always_comb legal = (ns_in <= NS_MAX_V) && (l_in <= L_MAX_V);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            valid <= 1'b0;
            err   <= 1'b0;
            cinit <= '0;
            acc   <= '0;
            cnt   <= '0;
            a     <= '0;
            b     <= '0;
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (start) begin
                        if (legal) begin
                            a     <= symbol_term(ns_in, l_in);
                            b     <= {n_cell_id, 1'b1};
                            acc   <= '0;
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= MULT;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                MULT: begin
                    acc <= acc + partial(a, b, cnt);
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        state <= ADD;
                    end
                end
                ADD: begin
                    cinit <= final_sum(acc, b);
                    busy  <= 1'b0;
                    valid <= 1'b1;
                    state <= DONE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nrs_cinit_gen.sv
// Directed and randomized checks of nrs_cinit_gen against an arithmetic model
// of the c_init formula, latency and handshake behaviour.
module tb_nrs_cinit_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  ns_in;
    logic [2:0]  l_in;
    logic [8:0]  n_cell_id;
    logic        busy;
    logic [30:0] cinit;
    logic        valid;
    logic        err;

    int     vectors = 0;
    int     miscompares = 0;
    longint exp_cinit = 0;

    int bns [5];
    int bl  [5];
    int bn  [5];

    always #5 clk = ~clk;

    nrs_cinit_gen dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ns_in     (ns_in),
        .l_in      (l_in),
        .n_cell_id (n_cell_id),
        .busy      (busy),
        .cinit     (cinit),
        .valid     (valid),
        .err       (err)
    );

    function automatic longint ref_cinit(input int ns, input int l, input int n);
        longint s;
        longint c;
        s = 7 * (ns + 1) + l + 1;
        c = 2 * n + 1;
        return s * c * 1024 + c;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic drive_ops(input int ns, input int l, input int n);
        ns_in     = 5'(ns);
        l_in      = 3'(l);
        n_cell_id = 9'(n);
    endtask

    // One request from an idle DUT; optional start pulse in cycle pulse_at of the computation
    task automatic request(input int ns, input int l, input int n, input int pulse_at);
        int  cyc;
        int  busy_cycles;
        bit  seen;
        bit  legal;
        legal = (ns <= 19) && (l <= 6);
        @(negedge clk);
        start = 1'b1;
        drive_ops(ns, l, n);
        @(negedge clk);
        start = 1'b0;
        drive_ops($urandom_range(31), $urandom_range(7), $urandom_range(511));
        cyc = 1;
        if (legal) begin
            busy_cycles = 0;
            while (!valid && cyc < 40) begin
                busy_cycles += int'(busy);
                if (cyc == pulse_at) begin
                    start = 1'b1;
                    drive_ops($urandom_range(19), $urandom_range(6), $urandom_range(503));
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
            start = 1'b0;
            exp_cinit = ref_cinit(ns, l, n);
            chk("latency", 64'(cyc), 64'd12);
            chk("busy_cycles", 64'(busy_cycles), 64'd11);
            chk("cinit", 64'(cinit), 64'(exp_cinit));
            @(negedge clk);
            chk("valid_pulse_end", 64'(valid), 64'd0);
        end else begin
            chk("err_pulse", 64'(err), 64'd1);
            chk("busy_on_reject", 64'(busy), 64'd0);
            @(negedge clk);
            chk("err_pulse_end", 64'(err), 64'd0);
            seen = 1'b0;
            repeat (14) begin
                seen |= valid;
                @(negedge clk);
            end
            chk("no_valid_on_reject", 64'(seen), 64'd0);
            chk("cinit_held", 64'(cinit), 64'(exp_cinit));
        end
    endtask

    initial begin
        int  cyc;
        bit  seen;
        rst   = 1'b1;
        start = 1'b0;
        drive_ops(0, 0, 0);
        repeat (2) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_valid", 64'(valid), 64'd0);
        chk("reset_err", 64'(err), 64'd0);
        chk("reset_cinit", 64'(cinit), 64'd0);
        rst = 1'b0;

        request(0, 5, 0, 0);
        chk("const_13313", 64'(cinit), 64'd13313);
        request(0, 6, 0, 0);
        chk("const_14337", 64'(cinit), 64'd14337);
        request(3, 5, 1, 5);
        chk("const_104451", 64'(cinit), 64'd104451);
        request(19, 6, 503, 0);
        chk("const_max", 64'(cinit), 64'd151582703);

        // start held high through several results with alternating l
        for (int i = 0; i < 5; i++) begin
            bns[i] = $urandom_range(19);
            bl[i]  = (i % 2 == 0) ? 5 : 6;
            bn[i]  = $urandom_range(503);
        end
        @(negedge clk);
        start = 1'b1;
        drive_ops(bns[0], bl[0], bn[0]);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i < 3) drive_ops(bns[i+1], bl[i+1], bn[i+1]);
            else start = 1'b0;
            cyc = 1;
            while (!valid && cyc < 40) begin
                @(negedge clk);
                cyc++;
            end
            exp_cinit = ref_cinit(bns[i], bl[i], bn[i]);
            chk("b2b_interval", 64'(cyc), 64'd12);
            chk("b2b_cinit", 64'(cinit), 64'(exp_cinit));
        end
        start = 1'b0;
        @(negedge clk);

        request(20, 5, 7, 0);
        request(0, 7, 7, 0);

        // asynchronous reset in the fifth multiply cycle
        @(negedge clk);
        start = 1'b1;
        drive_ops(11, 4, 321);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_valid", 64'(valid), 64'd0);
        chk("rst_mid_err", 64'(err), 64'd0);
        chk("rst_mid_cinit", 64'(cinit), 64'd0);
        exp_cinit = 0;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            seen |= valid;
            @(negedge clk);
        end
        chk("rst_no_valid", 64'(seen), 64'd0);
        request(7, 3, 200, 0);

        for (int i = 0; i < 10; i++) begin
            request($urandom_range(19), $urandom_range(6), $urandom_range(503),
                    $urandom_range(1, 11));
        end
        request(31, $urandom_range(7), $urandom_range(511), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
